// File: rtl/dm_mem_ctrl_pkg.sv
// Shared debug-memory constants, address map and FSM encoding for the
// hart-side memory controller.
package DM;

    typedef enum logic [1:0] {
        IDLE,
        GO,
        CMD_EXEC
    } dm_ctrl_state_e;

    localparam logic [2:0] CmdErrException  = 3'd3;
    localparam logic [2:0] CmdErrHaltResume = 3'd4;

    localparam int unsigned DataCount   = 2;
    localparam int unsigned ProgBufSize = 8;

    localparam int unsigned HaltedAddr    = 32'h100;
    localparam int unsigned GoingAddr     = 32'h108;
    localparam int unsigned ResumingAddr  = 32'h110;
    localparam int unsigned ExceptionAddr = 32'h118;
    localparam int unsigned WhereToAddr   = 32'h300;
    localparam int unsigned DataAddr      = 32'h380;
    localparam int unsigned FlagsBaseAddr = 32'h400;
    localparam int unsigned FlagsEndAddr  = 32'h7FF;
    localparam int unsigned HaltAddress   = 32'h800;

    // Program buffer sits directly below the data words, abstract command below that.
    localparam int unsigned DataEndAddr     = DataAddr + 4 * DataCount - 1;
    localparam int unsigned ProgBufBaseAddr = DataAddr - 4 * ProgBufSize;
    localparam int unsigned AbsCmdBaseAddr  = ProgBufBaseAddr - 40;

endpackage

// File: rtl/dm_mem_ctrl_addr_decode.sv
// Combinational decode of a hart bus access into one-hot debug-memory
// write/read strobes; unmapped or read-only targets raise nothing.
module dm_addr_decode
    import DM::*;
#(
    parameter int unsigned DbgAddressBits = 12,
    parameter int unsigned BusWidth       = 32
) (
    input  logic                req_i,
    input  logic                we_i,
    input  logic [BusWidth-1:0] addr_i,
    output logic                wr_halted_en_o,
    output logic                wr_going_en_o,
    output logic                wr_resuming_en_o,
    output logic                wr_exception_en_o,
    output logic                wr_data_en_o,
    output logic                rd_where_en_o,
    output logic                rd_data_en_o,
    output logic                rd_prog_en_o,
    output logic                rd_abs_cmd_en_o,
    output logic                rd_flags_en_o
);

    logic [31:0] a;
    logic        wr;
    logic        rd;
    logic        in_data;

    assign a       = 32'(addr_i[DbgAddressBits-1:0]);
    assign wr      = req_i & we_i;
    assign rd      = req_i & ~we_i;
    assign in_data = (a >= DataAddr) && (a <= DataEndAddr);

    assign wr_halted_en_o    = wr && (a == HaltedAddr);
    assign wr_going_en_o     = wr && (a == GoingAddr);
    assign wr_resuming_en_o  = wr && (a == ResumingAddr);
    assign wr_exception_en_o = wr && (a == ExceptionAddr);
    assign wr_data_en_o      = wr && in_data;

    // The ROM owns everything from HaltAddress up, which the flags range stops short of.
    assign rd_where_en_o   = rd && (a == WhereToAddr);
    assign rd_data_en_o    = rd && in_data;
    assign rd_prog_en_o    = rd && (a >= ProgBufBaseAddr) && (a < DataAddr);
    assign rd_abs_cmd_en_o = rd && (a >= AbsCmdBaseAddr) && (a < ProgBufBaseAddr);
    assign rd_flags_en_o   = rd && (a >= FlagsBaseAddr) && (a <= FlagsEndAddr);

endmodule

// File: rtl/dm_mem_ctrl.sv
// Hart-side debug memory controller: access strobes, registered response
// and the abstract-command IDLE/GO/CMD_EXEC sequencer.
module dm_mem_ctrl
    import DM::*;
#(
    parameter int unsigned DbgAddressBits = 12,
    parameter int unsigned BusWidth       = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [BusWidth-1:0] addr_i,
    input  logic                ndmreset_i,
    input  logic                halted_i,
    input  logic                cmd_valid_i,
    input  logic                resumereq_i,
    output logic                wr_halted_en_o,
    output logic                wr_going_en_o,
    output logic                wr_resuming_en_o,
    output logic                wr_exception_en_o,
    output logic                wr_data_en_o,
    output logic                rd_where_en_o,
    output logic                rd_data_en_o,
    output logic                rd_prog_en_o,
    output logic                rd_abs_cmd_en_o,
    output logic                rd_flags_en_o,
    output logic [BusWidth-1:0] mem_addr_o,
    output logic                rom_req_o,
    output logic                rvalid_o,
    output logic                cmdbusy_o,
    output logic                go_o,
    output logic                resume_o,
    output logic                cmderror_valid_o,
    output logic [2:0]          cmderror_o
);

    dm_ctrl_state_e state_q, state_d;
    logic           resume_q, resume_d;
    logic           go_q, busy_q, rvalid_q;
    logic           err_valid_q, err_valid_d;
    logic [2:0]     err_q, err_d;

    dm_addr_decode #(
        .DbgAddressBits(DbgAddressBits),
        .BusWidth      (BusWidth)
    ) u_decode (
        .req_i            (req_i),
        .we_i             (we_i),
        .addr_i           (addr_i),
        .wr_halted_en_o   (wr_halted_en_o),
        .wr_going_en_o    (wr_going_en_o),
        .wr_resuming_en_o (wr_resuming_en_o),
        .wr_exception_en_o(wr_exception_en_o),
        .wr_data_en_o     (wr_data_en_o),
        .rd_where_en_o    (rd_where_en_o),
        .rd_data_en_o     (rd_data_en_o),
        .rd_prog_en_o     (rd_prog_en_o),
        .rd_abs_cmd_en_o  (rd_abs_cmd_en_o),
        .rd_flags_en_o    (rd_flags_en_o)
    );

    assign mem_addr_o       = addr_i;
    assign rom_req_o        = req_i;
    assign rvalid_o         = rvalid_q;
    assign cmdbusy_o        = busy_q;
    assign go_o             = go_q;
    assign resume_o         = resume_q;
    assign cmderror_valid_o = err_valid_q;
    assign cmderror_o       = err_q;

    always_comb begin
        state_d     = state_q;
        resume_d    = resume_q;
        err_valid_d = 1'b0;
        err_d       = 3'd0;
        case (state_q)
            IDLE: begin
                // A new command takes precedence over a same-cycle resume request.
                if (cmd_valid_i) begin
                    if (halted_i) begin
                        state_d = GO;
                    end else begin
                        err_valid_d = 1'b1;
                        err_d       = CmdErrHaltResume;
                    end
                end else if (resumereq_i && halted_i) begin
                    resume_d = 1'b1;
                end
            end
            GO: begin
                if (wr_exception_en_o) begin
                    state_d     = IDLE;
                    err_valid_d = 1'b1;
                    err_d       = CmdErrException;
                end else if (wr_going_en_o) begin
                    state_d = CMD_EXEC;
                end
            end
            CMD_EXEC: begin
                if (wr_exception_en_o) begin
                    state_d     = IDLE;
                    err_valid_d = 1'b1;
                    err_d       = CmdErrException;
                end else if (wr_halted_en_o) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (wr_resuming_en_o) begin
            resume_d = 1'b0;
        end
        if (ndmreset_i) begin
            state_d     = IDLE;
            resume_d    = 1'b0;
            err_valid_d = 1'b0;
            err_d       = 3'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            resume_q    <= 1'b0;
            go_q        <= 1'b0;
            busy_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            err_valid_q <= 1'b0;
            err_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            go_q        <= (state_d == GO);
            busy_q      <= (state_d != IDLE);
            rvalid_q    <= req_i;
            err_valid_q <= err_valid_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_dm_mem_ctrl.sv
// Self-checking bench for dm_mem_ctrl: decode vector table, response
// scoreboard and hand-written command/resume/reset sequences.
module tb_dm_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_i, we_i, ndmreset_i, halted_i, cmd_valid_i, resumereq_i;
    logic [31:0] addr_i;
    logic        wr_halted_en_o, wr_going_en_o, wr_resuming_en_o, wr_exception_en_o, wr_data_en_o;
    logic        rd_where_en_o, rd_data_en_o, rd_prog_en_o, rd_abs_cmd_en_o, rd_flags_en_o;
    logic [31:0] mem_addr_o;
    logic        rom_req_o, rvalid_o, cmdbusy_o, go_o, resume_o, cmderror_valid_o;
    logic [2:0]  cmderror_o;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    bit sb_en = 1'b0;
    logic [0:0] exp_q[$];

    dm_mem_ctrl #(.DbgAddressBits(12), .BusWidth(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .ndmreset_i(ndmreset_i), .halted_i(halted_i), .cmd_valid_i(cmd_valid_i),
        .resumereq_i(resumereq_i),
        .wr_halted_en_o(wr_halted_en_o), .wr_going_en_o(wr_going_en_o),
        .wr_resuming_en_o(wr_resuming_en_o), .wr_exception_en_o(wr_exception_en_o),
        .wr_data_en_o(wr_data_en_o), .rd_where_en_o(rd_where_en_o),
        .rd_data_en_o(rd_data_en_o), .rd_prog_en_o(rd_prog_en_o),
        .rd_abs_cmd_en_o(rd_abs_cmd_en_o), .rd_flags_en_o(rd_flags_en_o),
        .mem_addr_o(mem_addr_o), .rom_req_o(rom_req_o), .rvalid_o(rvalid_o),
        .cmdbusy_o(cmdbusy_o), .go_o(go_o), .resume_o(resume_o),
        .cmderror_valid_o(cmderror_valid_o), .cmderror_o(cmderror_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [9:0] strobes();
        return {wr_halted_en_o, wr_going_en_o, wr_resuming_en_o, wr_exception_en_o,
                wr_data_en_o, rd_where_en_o, rd_data_en_o, rd_prog_en_o,
                rd_abs_cmd_en_o, rd_flags_en_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic we, input logic [31:0] addr);
        req_i  = 1'b1;
        we_i   = we;
        addr_i = addr;
        #1;
    endtask

    task automatic bus_idle();
        req_i  = 1'b0;
        we_i   = 1'b0;
        addr_i = 32'h0;
    endtask

    // response scoreboard: every sampled request must be answered next cycle
    always @(posedge clk) begin
        if (sb_en) begin
            exp_q.push_back(rst_ni ? req_i : 1'b0);
            #1;
            chk("rvalid", {31'd0, rvalid_o}, {31'd0, exp_q.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (cmderror_valid_o) err_pulses++;
    end

    // strobe order: wr_halted wr_going wr_resuming wr_exception wr_data
    //               rd_where rd_data rd_prog rd_abs_cmd rd_flags
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [9:0]  exp_strb;
    } vec_t;

    vec_t vecs[25];

    initial begin
        rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0;
        ndmreset_i = 1'b0; halted_i = 1'b0; cmd_valid_i = 1'b0; resumereq_i = 1'b0;

        vecs[0]  = '{1'b0, 32'h300, 10'b00000_10000};
        vecs[1]  = '{1'b0, 32'h380, 10'b00000_01000};
        vecs[2]  = '{1'b0, 32'h387, 10'b00000_01000};
        vecs[3]  = '{1'b0, 32'h388, 10'b00000_00000};
        vecs[4]  = '{1'b0, 32'h360, 10'b00000_00100};
        vecs[5]  = '{1'b0, 32'h37C, 10'b00000_00100};
        vecs[6]  = '{1'b0, 32'h338, 10'b00000_00010};
        vecs[7]  = '{1'b0, 32'h35F, 10'b00000_00010};
        vecs[8]  = '{1'b0, 32'h334, 10'b00000_00000};
        vecs[9]  = '{1'b0, 32'h400, 10'b00000_00001};
        vecs[10] = '{1'b0, 32'h7FF, 10'b00000_00001};
        vecs[11] = '{1'b0, 32'h800, 10'b00000_00000};
        vecs[12] = '{1'b0, 32'hFFC, 10'b00000_00000};
        vecs[13] = '{1'b0, 32'h100, 10'b00000_00000};
        vecs[14] = '{1'b0, 32'h1234_5300, 10'b00000_10000};
        vecs[15] = '{1'b1, 32'h100, 10'b10000_00000};
        vecs[16] = '{1'b1, 32'h108, 10'b01000_00000};
        vecs[17] = '{1'b1, 32'h110, 10'b00100_00000};
        vecs[18] = '{1'b1, 32'h118, 10'b00010_00000};
        vecs[19] = '{1'b1, 32'h384, 10'b00001_00000};
        vecs[20] = '{1'b1, 32'h360, 10'b00000_00000};
        vecs[21] = '{1'b1, 32'h300, 10'b00000_00000};
        vecs[22] = '{1'b1, 32'h400, 10'b00000_00000};
        vecs[23] = '{1'b1, 32'h104, 10'b00000_00000};
        vecs[24] = '{1'b1, 32'h800, 10'b00000_00000};

        // reset with a request held
        sb_en = 1'b1;
        tick(); tick();
        chk("rst_strobes", {22'd0, strobes()}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("rst_flags", {28'd0, cmdbusy_o, go_o, resume_o, cmderror_valid_o}, 32'd0);
        chk("rst_cmderror", {29'd0, cmderror_o}, 32'd0);
        rst_ni = 1'b1;
        tick();
        chk("rvalid_after_release", {31'd0, rvalid_o}, 32'd1);
        bus_idle();
        tick();

        // decode table
        for (int i = 0; i < 25; i++) begin
            bus(vecs[i].we, vecs[i].addr);
            chk($sformatf("strobes_%0d", i), {22'd0, strobes()}, {22'd0, vecs[i].exp_strb});
            chk($sformatf("mem_addr_%0d", i), mem_addr_o, vecs[i].addr);
            chk($sformatf("rom_req_%0d", i), {31'd0, rom_req_o}, 32'd1);
            tick();
        end
        bus_idle();
        tick();

        // random flags-region reads, upper address bits must be ignored
        for (int i = 0; i < 8; i++) begin
            bus(1'b0, ($urandom() & 32'hFFFF_F000) | (32'h400 + $urandom_range(0, 32'h3FF)));
            chk("rand_flags", {22'd0, strobes()}, 32'h001);
            tick();
            if ($urandom_range(0, 1) == 1) begin
                bus_idle();
                tick();
            end
        end
        bus_idle();
        tick();

        // command happy path
        halted_i = 1'b1;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        chk("go_busy", {30'd0, cmdbusy_o, go_o}, 32'b11);
        bus(1'b1, 32'h108);
        chk("going_strobe", {31'd0, wr_going_en_o}, 32'd1);
        tick();
        bus_idle();
        chk("exec_busy", {30'd0, cmdbusy_o, go_o}, 32'b10);
        tick();
        chk("exec_hold", {30'd0, cmdbusy_o, go_o}, 32'b10);
        bus(1'b1, 32'h100);
        tick();
        bus_idle();
        chk("done_busy", {30'd0, cmdbusy_o, go_o}, 32'b00);
        tick();
        chk("no_err_happy", err_pulses, 32'd0);

        // command while not halted
        halted_i = 1'b0;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        chk("haltres_valid", {31'd0, cmderror_valid_o}, 32'd1);
        chk("haltres_code", {29'd0, cmderror_o}, 32'd4);
        chk("haltres_busy", {31'd0, cmdbusy_o}, 32'd0);
        tick();
        chk("haltres_once", {31'd0, cmderror_valid_o}, 32'd0);
        chk("haltres_pulses", err_pulses, 32'd1);

        // exception during CMD_EXEC
        halted_i = 1'b1;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        bus(1'b1, 32'h108);
        tick();
        bus(1'b1, 32'h118);
        chk("exc_strobe", {31'd0, wr_exception_en_o}, 32'd1);
        tick();
        bus_idle();
        chk("exc_valid", {31'd0, cmderror_valid_o}, 32'd1);
        chk("exc_code", {29'd0, cmderror_o}, 32'd3);
        chk("exc_busy", {31'd0, cmdbusy_o}, 32'd0);
        tick();
        chk("exc_once", {31'd0, cmderror_valid_o}, 32'd0);

        // resume request and its clear
        resumereq_i = 1'b1;
        tick();
        resumereq_i = 1'b0;
        chk("resume_set", {31'd0, resume_o}, 32'd1);
        tick();
        chk("resume_hold", {31'd0, resume_o}, 32'd1);
        bus(1'b1, 32'h110);
        tick();
        bus_idle();
        chk("resume_clr", {31'd0, resume_o}, 32'd0);

        // command beats a same-cycle resume; halted write in GO does not move state
        cmd_valid_i = 1'b1;
        resumereq_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        resumereq_i = 1'b0;
        chk("cmd_wins_resume", {31'd0, resume_o}, 32'd0);
        chk("cmd_wins_go", {31'd0, go_o}, 32'd1);
        bus(1'b1, 32'h100);
        chk("go_halted_strobe", {31'd0, wr_halted_en_o}, 32'd1);
        tick();
        bus_idle();
        chk("go_halted_stay", {30'd0, cmdbusy_o, go_o}, 32'b11);

        // ndmreset out of GO, with a request in flight
        ndmreset_i = 1'b1;
        bus(1'b0, 32'h300);
        tick();
        ndmreset_i = 1'b0;
        bus_idle();
        chk("ndm_flags", {29'd0, cmdbusy_o, go_o, resume_o}, 32'd0);
        chk("ndm_rvalid", {31'd0, rvalid_o}, 32'd1);
        bus(1'b1, 32'h108);
        tick();
        bus_idle();
        chk("ndm_idle", {31'd0, cmdbusy_o}, 32'd0);
        tick();
        chk("total_pulses", err_pulses, 32'd2);

        sb_en = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
